mmio_bus_arbiter: RTL and testbench

//  Sequences the CPU data port onto data BRAM and MMIO (LED, switch, tube) and shares the BRAM with the UART program loader.

---
 rtl/mmio_bus_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mmio_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bus_arbiter
// Description : Connects the CPU data port to the data BRAM and to the MMIO
//               registers (LED, switch, seven-segment tube). It also shares
//               the BRAM write port with the UART program loader. Each
//               cycle at most one requester is granted. Load data returns
//               exactly one cycle after the load grant.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro : MMIO_ERR_EN
//   When defined, oBusErr is a sticky flag. It is set when a CPU access is
//   granted to an unmapped IO offset, or when a store targets a switch
//   address. Only iRst clears it. When the macro is undefined, oBusErr is
//   tied to 0.
// ----------------------------------------------------------------------------
// Ports
//   iClk, iRst           clock; synchronous active-high reset
//   iCpuReq/We/Addr/Wdata CPU request (held until oCpuGnt), byte address
//   oCpuGnt              1-cycle CPU grant (access executes this cycle)
//   oCpuRvalid/oCpuRdata load data, cycle after a load grant
//   iLdReq/Addr/Wdata    loader write request (word address)
//   oLdGnt               1-cycle loader grant
//   oMemAddr/We/Wdata    BRAM port (address holds outside grants)
//   iMemRdata            BRAM read data, 1 cycle after address
//   iSwitch              switch inputs
//   oLed, oTube          LED and tube registers
//   oBusErr              sticky unmapped-IO flag
// ============================================================================
module mmio_bus_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int LED_W        = 24,
    parameter int SW_W         = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iCpuReq,
    input  logic              iCpuWe,
    input  logic [31:0]       iCpuAddr,
    input  logic [31:0]       iCpuWdata,
    output logic              oCpuGnt,
    output logic              oCpuRvalid,
    output logic [31:0]       oCpuRdata,
    input  logic              iLdReq,
    input  logic [ADDR_W-1:0] iLdAddr,
    input  logic [31:0]       iLdWdata,
    output logic              oLdGnt,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemWe,
    output logic [31:0]       oMemWdata,
    input  logic [31:0]       iMemRdata,
    input  logic [SW_W-1:0]   iSwitch,
    output logic [LED_W-1:0]  oLed,
    output logic [31:0]       oTube,
    output logic              oBusErr
);

    localparam logic [7:0] c_off_led_lo = 8'h60;
    localparam logic [7:0] c_off_led_hi = 8'h62;
    localparam logic [7:0] c_off_sw_lo  = 8'h70;
    localparam logic [7:0] c_off_sw_hi  = 8'h72;
    localparam logic [7:0] c_off_tube   = 8'h80;

    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } rd_state_t;

    rd_state_t r_state;
    rd_state_t w_state_nxt;

    logic [LED_W-1:0]      r_led;
    logic [31:0]           r_tube;
    logic [c_starve_w-1:0] r_starve;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic                  r_rd_io;
    logic [31:0]           r_io_rdata;

    logic              w_io;
    logic [7:0]        w_off;
    logic              w_cpu_gnt;
    logic              w_ld_gnt;
    logic              w_cpu_load;
    logic              w_mem_drive;
    logic [ADDR_W-1:0] w_mem_addr_sel;
    logic [31:0]       w_io_rdata;
    logic              w_unused_addr;

    assign w_io          = &iCpuAddr[31:10];
    assign w_off         = iCpuAddr[7:0];
    assign w_unused_addr = ^iCpuAddr[1:0];

    // The loader wins a contested cycle unless the CPU has already waited
    // through STARVE_LIMIT loader grants. No grants are issued while the
    // block is in reset, so every output stays quiet during that cycle.
    assign w_ld_gnt   = !iRst && iLdReq && !(iCpuReq && (r_starve == c_starve_max));
    assign w_cpu_gnt  = !iRst && iCpuReq && !w_ld_gnt;
    assign w_cpu_load = w_cpu_gnt && !iCpuWe;

    assign oCpuGnt = w_cpu_gnt;
    assign oLdGnt  = w_ld_gnt;

    // The BRAM port is driven only for loader grants and for CPU accesses
    // that decode to BRAM. IO accesses leave the held address untouched.
    assign w_mem_drive    = w_ld_gnt || (w_cpu_gnt && !w_io);
    assign w_mem_addr_sel = w_ld_gnt ? iLdAddr : iCpuAddr[ADDR_W+1:2];
    assign oMemAddr       = w_mem_drive ? w_mem_addr_sel : r_mem_addr;
    assign oMemWe         = w_ld_gnt || (w_cpu_gnt && !w_io && iCpuWe);
    assign oMemWdata      = w_ld_gnt ? iLdWdata : ((w_cpu_gnt && !w_io) ? iCpuWdata : 32'd0);

    assign oLed  = r_led;
    assign oTube = r_tube;

    // IO read value, captured at the load grant so it lines up with the
    // BRAM data returning on the following cycle.
    always_comb begin
        w_io_rdata = 32'd0;
        case (w_off)
            c_off_led_lo: w_io_rdata = 32'(r_led[15:0]);
            c_off_led_hi: w_io_rdata = 32'(r_led[LED_W-1:16]);
            c_off_sw_lo:  w_io_rdata = 32'(iSwitch[15:0]);
            c_off_sw_hi:  w_io_rdata = 32'(iSwitch[SW_W-1:16]);
            c_off_tube:   w_io_rdata = r_tube;
            default:      w_io_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_led      <= '0;
            r_tube     <= '0;
            r_starve   <= '0;
            r_mem_addr <= '0;
            r_rd_io    <= 1'b0;
            r_io_rdata <= '0;
        end else begin
            if (w_mem_drive) begin
                r_mem_addr <= w_mem_addr_sel;
            end

            if (!iCpuReq || w_cpu_gnt) begin
                r_starve <= '0;
            end else if (w_ld_gnt && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + 1'b1;
            end

            if (w_cpu_gnt && w_io && iCpuWe) begin
                case (w_off)
                    c_off_led_lo: r_led[15:0]       <= iCpuWdata[15:0];
                    c_off_led_hi: r_led[LED_W-1:16] <= iCpuWdata[LED_W-17:0];
                    c_off_tube:   r_tube            <= iCpuWdata;
                    default:      ;
                endcase
            end

            if (w_cpu_load) begin
                r_rd_io    <= w_io;
                r_io_rdata <= w_io_rdata;
            end
        end
    end

    // Read-return FSM: state register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read-return FSM: next state and outputs. Outputs are masked during
    // reset, so a load granted just before reset never returns data.
    always_comb begin
        w_state_nxt = r_state;
        oCpuRvalid  = 1'b0;
        oCpuRdata   = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_load) w_state_nxt = S_PEND;
            end
            S_PEND: begin
                oCpuRvalid  = !iRst;
                oCpuRdata   = iRst ? 32'd0 : (r_rd_io ? r_io_rdata : iMemRdata);
                w_state_nxt = w_cpu_load ? S_PEND : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef MMIO_ERR_EN
    logic r_bus_err;
    logic w_io_mapped;
    logic w_err_hit;

    assign w_io_mapped = (w_off == c_off_led_lo) || (w_off == c_off_led_hi) ||
                         (w_off == c_off_sw_lo)  || (w_off == c_off_sw_hi)  ||
                         (w_off == c_off_tube);
    assign w_err_hit   = w_cpu_gnt && w_io &&
                         (!w_io_mapped ||
                          (iCpuWe && ((w_off == c_off_sw_lo) || (w_off == c_off_sw_hi))));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_bus_err <= 1'b0;
        end else if (w_err_hit) begin
            r_bus_err <= 1'b1;
        end
    end

    assign oBusErr = r_bus_err;
`else
    assign oBusErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_bus_arbiter
// Description : Self-checking bench for mmio_bus_arbiter. It applies a table
//               of per-cycle vectors, followed by hand-written sequences for
//               starvation, bus errors and reset during a pending read.
//               The bench also contains a small BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ld_req;
    logic [13:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [23:0] sw;
    logic [23:0] led;
    logic [31:0] tube;
    logic        bus_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mmio_bus_arbiter #(
        .ADDR_W(14), .LED_W(24), .SW_W(24), .STARVE_LIMIT(4)
    ) dut (
        .iClk(clk), .iRst(rst),
        .iCpuReq(cpu_req), .iCpuWe(cpu_we), .iCpuAddr(cpu_addr), .iCpuWdata(cpu_wdata),
        .oCpuGnt(cpu_gnt), .oCpuRvalid(cpu_rvalid), .oCpuRdata(cpu_rdata),
        .iLdReq(ld_req), .iLdAddr(ld_addr), .iLdWdata(ld_wdata), .oLdGnt(ld_gnt),
        .oMemAddr(mem_addr), .oMemWe(mem_we), .oMemWdata(mem_wdata), .iMemRdata(mem_rdata),
        .iSwitch(sw), .oLed(led), .oTube(tube), .oBusErr(bus_err)
    );

    // Synchronous BRAM model: read-before-write, 1-cycle read latency
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        cr;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        lr;
        logic [13:0] la;
        logic [31:0] lw;
        logic        e_cg;
        logic        e_lg;
        logic        e_we;
        logic [13:0] e_ma;
        logic        e_rv;
        logic [31:0] e_rd;
        logic [23:0] e_led;
        logic [31:0] e_tube;
    } vec_t;

    vec_t vecs [16];

    task automatic set_in(input logic cr, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic lr, input logic [13:0] la,
                          input logic [31:0] lw);
        cpu_req = cr; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        ld_req = lr; ld_addr = la; ld_wdata = lw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 14'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic exp_err;
    logic exp_l, exp_c;

    initial begin
        rst = 1'b1;
        sw  = 24'h123456;
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 14'd0, 32'd0);
`ifdef MMIO_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        //            cr    we    addr          wdata         lr    la      lw            cg    lg    we    ma      rv    rd            led         tube
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 14'd0,  32'h0,        1'b0, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        24'h0,      32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'hFFFFFC60, 32'h0000ABCD, 1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        24'h0,      32'h0};
        vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFC62, 32'h000000EF, 1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        24'h00ABCD, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'hFFFFFC80, 32'hCAFEF00D, 1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        24'hEFABCD, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'hFFFFFC72, 32'h0,        1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        24'hEFABCD, 32'hCAFEF00D};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFFFC70, 32'h0,        1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd0,  1'b1, 32'h12,       24'hEFABCD, 32'hCAFEF00D};
        vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFC62, 32'h0,        1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd0,  1'b1, 32'h3456,     24'hEFABCD, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 1'b0, 32'hFFFFFC80, 32'h0,        1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd0,  1'b1, 32'hEF,       24'hEFABCD, 32'hCAFEF00D};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFFFC90, 32'h0,        1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd0,  1'b1, 32'hCAFEF00D, 24'hEFABCD, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFFFC70, 32'hFFFFFFFF, 1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd0,  1'b1, 32'h0,        24'hEFABCD, 32'hCAFEF00D};
        vecs[10] = '{1'b1, 1'b1, 32'h000000F4, 32'hDEADBEEF, 1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b1, 14'd61, 1'b0, 32'h0,        24'hEFABCD, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 1'b0, 32'h000000F4, 32'h0,        1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd61, 1'b0, 32'h0,        24'hEFABCD, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 14'd100, 32'h11112222, 1'b0, 1'b1, 1'b1, 14'd100, 1'b1, 32'hDEADBEEF, 24'hEFABCD, 32'hCAFEF00D};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 14'd0,  32'h0,        1'b0, 1'b0, 1'b0, 14'd100, 1'b0, 32'h0,        24'hEFABCD, 32'hCAFEF00D};
        vecs[14] = '{1'b1, 1'b0, 32'h00000190, 32'h0,        1'b0, 14'd0,  32'h0,        1'b1, 1'b0, 1'b0, 14'd100, 1'b0, 32'h0,        24'hEFABCD, 32'hCAFEF00D};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 14'd0,  32'h0,        1'b0, 1'b0, 1'b0, 14'd100, 1'b1, 32'h11112222, 24'hEFABCD, 32'hCAFEF00D};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(vecs[i].cr, vecs[i].we, vecs[i].addr, vecs[i].wd,
                   vecs[i].lr, vecs[i].la, vecs[i].lw);
            #2;
            chk($sformatf("v%0d cpu_gnt", i),  32'(cpu_gnt),    32'(vecs[i].e_cg));
            chk($sformatf("v%0d ld_gnt", i),   32'(ld_gnt),     32'(vecs[i].e_lg));
            chk($sformatf("v%0d mem_we", i),   32'(mem_we),     32'(vecs[i].e_we));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr),   32'(vecs[i].e_ma));
            chk($sformatf("v%0d rvalid", i),   32'(cpu_rvalid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d rdata", i),    cpu_rdata,       vecs[i].e_rd);
            chk($sformatf("v%0d led", i),      32'(led),        32'(vecs[i].e_led));
            chk($sformatf("v%0d tube", i),     tube,            vecs[i].e_tube);
            @(negedge clk);
        end
        #2;
        chk("bus_err after table", 32'(bus_err), 32'(exp_err));

        // Unmapped store leaves registers intact and raises the error flag
        do_reset();
        #2;
        chk("bus_err after reset", 32'(bus_err), 32'd0);
        chk("led after reset", 32'(led), 32'd0);
        set_in(1'b1, 1'b1, 32'hFFFFFC60, 32'h00001357, 1'b0, 14'd0, 32'h0);
        @(negedge clk);
        set_in(1'b1, 1'b1, 32'hFFFFFC90, 32'h55555555, 1'b0, 14'd0, 32'h0);
        #2;
        chk("unmapped store gnt", 32'(cpu_gnt), 32'd1);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 14'd0, 32'h0);
        #2;
        chk("unmapped store led", 32'(led), 32'h001357);
        chk("unmapped store tube", tube, 32'h0);
        chk("unmapped store bus_err", 32'(bus_err), 32'(exp_err));
        @(negedge clk);
        #2;
        chk("bus_err sticky", 32'(bus_err), 32'(exp_err));

        // Starvation: both requesters held, pattern L L L L C repeating
        do_reset();
        set_in(1'b1, 1'b0, 32'h00000010, 32'h0, 1'b1, 14'd7, 32'h0);
        for (int c = 0; c < 11; c++) begin
            #2;
            exp_c = ((c % 5) == 4);
            exp_l = !exp_c;
            chk($sformatf("starve c%0d ld_gnt", c),  32'(ld_gnt),  32'(exp_l));
            chk($sformatf("starve c%0d cpu_gnt", c), 32'(cpu_gnt), 32'(exp_c));
            @(negedge clk);
        end
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 14'd0, 32'h0);

        // Reset arriving while a load is pending suppresses the return
        @(negedge clk);
        set_in(1'b1, 1'b0, 32'hFFFFFC80, 32'h0, 1'b0, 14'd0, 32'h0);
        #2;
        chk("rst-pend load gnt", 32'(cpu_gnt), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 14'd0, 32'h0);
        #2;
        chk("rst-pend rvalid in reset", 32'(cpu_rvalid), 32'd0);
        chk("rst-pend rdata in reset", cpu_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post-rst rvalid", 32'(cpu_rvalid), 32'd0);
        chk("post-rst led", 32'(led), 32'd0);
        chk("post-rst tube", tube, 32'd0);
        chk("post-rst mem_addr", 32'(mem_addr), 32'd0);
        chk("post-rst mem_we", 32'(mem_we), 32'd0);
        chk("post-rst mem_wdata", mem_wdata, 32'd0);
        chk("post-rst gnts", {30'd0, cpu_gnt, ld_gnt}, 32'd0);
        chk("post-rst bus_err", 32'(bus_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
